// File: rtl/rst_seq_wdog.sv
// rst_seq_wdog: power-on reset sequencer with run watchdog.
// Holds every reset domain for HOLD_CYCLES after rst_n/btn release. It then
// releases the domains one at a time, STAGGER cycles apart. After the last
// release it enters RUN and counts cycles until the core halts or the
// watchdog expires.
// Ports:
//   clk        in   clock, all state on rising edge
//   rst_n      in   asynchronous active-low reset
//   btn        in   asynchronous active-high reset request, synchronised here
//   halt       in   core finished (synchronous)
//   rst_out    out  [N_DOM] active-high domain resets, rst_out[0] released first
//   running    out  high while in RUN
//   done       out  sticky, halt seen in RUN
//   timeout    out  sticky, watchdog expired
//   cycle_cnt  out  [CNT_W] RUN cycle count, frozen once finished
module rst_seq_wdog #(
    parameter int unsigned N_DOM          = 2,
    parameter int unsigned HOLD_CYCLES    = 25,
    parameter int unsigned STAGGER        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 2500,
    parameter int unsigned CNT_W          = 32,
    parameter int unsigned BTN_SYNC       = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn,
    input  logic             halt,
    output logic [N_DOM-1:0] rst_out,
    output logic             running,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_cnt
);

    localparam int unsigned IDX_W = (N_DOM > 1) ? $clog2(N_DOM) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STG_LAST  = CNT_W'(STAGGER - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_DOM - 1);

    typedef enum logic [2:0] {
        S_HOLD,
        S_STAGGER,
        S_RUN,
        S_DONE,
        S_TIMEOUT
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    hold_q, hold_d;
    logic [CNT_W-1:0]    stg_q, stg_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [N_DOM-1:0]    rst_out_d;
    logic                running_d, done_d, timeout_d;
    logic [CNT_W-1:0]    cnt_d;
    logic [BTN_SYNC-1:0] sync_q;
    logic                btn_s;

    // Button synchroniser; the last stage is the only one used by the logic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[BTN_SYNC-2:0], btn};
        end
    end

    assign btn_s = sync_q[BTN_SYNC-1];

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_HOLD;
            hold_q    <= '0;
            stg_q     <= '0;
            idx_q     <= '0;
            rst_out   <= '1;
            running   <= 1'b0;
            done      <= 1'b0;
            timeout   <= 1'b0;
            cycle_cnt <= '0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            stg_q     <= stg_d;
            idx_q     <= idx_d;
            rst_out   <= rst_out_d;
            running   <= running_d;
            done      <= done_d;
            timeout   <= timeout_d;
            cycle_cnt <= cnt_d;
        end
    end

    // Next-state and next-output logic; btn_s overrides everything.
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        stg_d     = stg_q;
        idx_d     = idx_q;
        rst_out_d = rst_out;
        running_d = running;
        done_d    = done;
        timeout_d = timeout;
        cnt_d     = cycle_cnt;

        if (btn_s) begin
            state_d   = S_HOLD;
            hold_d    = '0;
            stg_d     = '0;
            idx_d     = '0;
            rst_out_d = '1;
            running_d = 1'b0;
            done_d    = 1'b0;
            timeout_d = 1'b0;
            cnt_d     = '0;
        end else begin
            case (state_q)
                S_HOLD: begin
                    if (hold_q == HOLD_LAST) begin
                        state_d      = S_STAGGER;
                        hold_d       = '0;
                        stg_d        = '0;
                        idx_d        = '0;
                        rst_out_d[0] = 1'b0;
                    end else begin
                        hold_d = hold_q + CNT_W'(1);
                    end
                end
                S_STAGGER: begin
                    if (stg_q == STG_LAST) begin
                        stg_d = '0;
                        if (idx_q == IDX_LAST) begin
                            state_d   = S_RUN;
                            running_d = 1'b1;
                        end else begin
                            idx_d            = idx_q + IDX_W'(1);
                            rst_out_d[idx_d] = 1'b0;
                        end
                    end else begin
                        stg_d = stg_q + CNT_W'(1);
                    end
                end
                S_RUN: begin
                    // The count advances on the exit edge too; it saturates at all-ones.
                    cnt_d = (cycle_cnt == '1) ? cycle_cnt : cycle_cnt + CNT_W'(1);
                    if (halt) begin
                        state_d   = S_DONE;
                        done_d    = 1'b1;
                        running_d = 1'b0;
                    end else if ((TIMEOUT_CYCLES != 0) && (cycle_cnt == TO_LAST)) begin
                        state_d   = S_TIMEOUT;
                        timeout_d = 1'b1;
                        running_d = 1'b0;
                    end
                end
                S_DONE, S_TIMEOUT: begin
                    state_d = state_q;
                end
                default: begin
                    state_d = S_HOLD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rst_seq_wdog.sv
// Testbench for rst_seq_wdog. The reference model tracks the number of edges
// since the last reset and derives every output from that count.
module tb_rst_seq_wdog;

    localparam int unsigned N_DOM  = 2;
    localparam int unsigned HOLD   = 25;
    localparam int unsigned STG    = 4;
    localparam int unsigned TO     = 100;
    localparam int unsigned CNT_W  = 32;
    localparam int unsigned BSYNC  = 2;
    localparam int unsigned RUN_AT = HOLD + N_DOM * STG;
    localparam int unsigned VW     = N_DOM + CNT_W + 3;
    localparam logic [VW-1:0] RST_VEC = {{N_DOM{1'b1}}, 3'b000, {CNT_W{1'b0}}};

    logic             clk;
    logic             rst_n;
    logic             btn;
    logic             halt;
    logic [N_DOM-1:0] rst_out;
    logic             running;
    logic             done;
    logic             timeout;
    logic [CNT_W-1:0] cycle_cnt;
    logic [VW-1:0]    obs;

    int n_tests;
    int n_fail;
    int edge_no;

    // Model state: edges since last reset, finish kind (0 none, 1 done, 2 timeout).
    int unsigned      m_el;
    int               m_fin;
    int unsigned      m_frozen;
    logic [BSYNC-1:0] bq;

    rst_seq_wdog #(
        .N_DOM(N_DOM),
        .HOLD_CYCLES(HOLD),
        .STAGGER(STG),
        .TIMEOUT_CYCLES(TO),
        .CNT_W(CNT_W),
        .BTN_SYNC(BSYNC)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .btn(btn),
        .halt(halt),
        .rst_out(rst_out),
        .running(running),
        .done(done),
        .timeout(timeout),
        .cycle_cnt(cycle_cnt)
    );

    assign obs = {rst_out, running, done, timeout, cycle_cnt};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [VW-1:0] exp_vec();
        logic [N_DOM-1:0] r;
        logic [CNT_W-1:0] c;
        r = '0;
        for (int unsigned i = 0; i < N_DOM; i++) begin
            if (m_el < HOLD + i * STG) r = r | (N_DOM'(1) << i);
        end
        if (m_fin != 0) c = CNT_W'(m_frozen);
        else if (m_el >= RUN_AT) c = CNT_W'(m_el - RUN_AT);
        else c = '0;
        return {r, (m_fin == 0) && (m_el >= RUN_AT), m_fin == 1, m_fin == 2, c};
    endfunction

    task automatic model_reset();
        m_el     = 0;
        m_fin    = 0;
        m_frozen = 0;
        bq       = '0;
        edge_no  = 0;
    endtask

    task automatic model_edge();
        logic        bd;
        int unsigned c;
        bd = bq[BSYNC-1];
        bq = {bq[BSYNC-2:0], btn};
        if (bd) begin
            m_el     = 0;
            m_fin    = 0;
            m_frozen = 0;
        end else if (m_fin == 0) begin
            if (m_el >= RUN_AT) begin
                c = m_el - RUN_AT;
                if (halt) begin
                    m_fin    = 1;
                    m_frozen = c + 1;
                end else if (c == TO - 1) begin
                    m_fin    = 2;
                    m_frozen = c + 1;
                end
            end
            m_el++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        edge_no++;
        #1;
    endtask

    task automatic do_reset();
        btn  = 1'b0;
        halt = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        btn   = 1'b0;
        halt  = 1'b0;
        #12;
        n_tests++;
        if (obs !== RST_VEC) begin
            n_fail++;
            $display("FAIL reset_state: got %h expected %h", obs, RST_VEC);
        end
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_power_on();
        logic [N_DOM-1:0] er;
        for (int e = 1; e <= 40; e++) begin
            step();
            n_tests++;
            if (obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL power_on edge %0d: got %h expected %h", edge_no, obs, exp_vec());
            end
            if (edge_no == 24 || edge_no == 25 || edge_no == 29) begin
                er = (edge_no == 24) ? 2'b11 : (edge_no == 25) ? 2'b10 : 2'b00;
                n_tests++;
                if (rst_out !== er) begin
                    n_fail++;
                    $display("FAIL power_on_rst edge %0d: got %b expected %b", edge_no, rst_out, er);
                end
            end
            if (edge_no == 32 || edge_no == 33) begin
                n_tests++;
                if (running !== (edge_no == 33)) begin
                    n_fail++;
                    $display("FAIL power_on_running edge %0d: got %b", edge_no, running);
                end
            end
        end
    endtask

    task automatic test_watchdog();
        while (edge_no < 133) begin
            step();
            n_tests++;
            if (obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL watchdog edge %0d: got %h expected %h", edge_no, obs, exp_vec());
            end
        end
        n_tests++;
        if (timeout !== 1'b1 || running !== 1'b0 || done !== 1'b0 || cycle_cnt !== 32'd100) begin
            n_fail++;
            $display("FAIL watchdog_fire: timeout=%b running=%b done=%b cnt=%0d expected 1 0 0 100",
                     timeout, running, done, cycle_cnt);
        end
        repeat (50) step();
        n_tests++;
        if (timeout !== 1'b1 || rst_out !== 2'b00 || cycle_cnt !== 32'd100) begin
            n_fail++;
            $display("FAIL watchdog_frozen: timeout=%b rst_out=%b cnt=%0d expected 1 00 100",
                     timeout, rst_out, cycle_cnt);
        end
    endtask

    task automatic test_halt();
        do_reset();
        while (edge_no < RUN_AT + 40) step();
        halt = 1'b1;
        step();
        halt = 1'b0;
        n_tests++;
        if (done !== 1'b1 || running !== 1'b0 || cycle_cnt !== 32'd41) begin
            n_fail++;
            $display("FAIL halt_done: done=%b running=%b cnt=%0d expected 1 0 41", done, running, cycle_cnt);
        end
        for (int i = 0; i < 100; i++) begin
            step();
            n_tests++;
            if (obs !== exp_vec() || timeout !== 1'b0) begin
                n_fail++;
                $display("FAIL halt_frozen edge %0d: got %h expected %h", edge_no, obs, exp_vec());
            end
        end
        n_tests++;
        if (cycle_cnt !== 32'd41 || timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_final: cnt=%0d timeout=%b expected 41 0", cycle_cnt, timeout);
        end
    endtask

    task automatic test_tie();
        do_reset();
        while (edge_no < RUN_AT + 99) step();
        halt = 1'b1;
        step();
        halt = 1'b0;
        n_tests++;
        if (done !== 1'b1 || timeout !== 1'b0 || cycle_cnt !== 32'd100) begin
            n_fail++;
            $display("FAIL tie: done=%b timeout=%b cnt=%0d expected 1 0 100", done, timeout, cycle_cnt);
        end
        repeat (5) step();
        n_tests++;
        if (timeout !== 1'b0 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL tie_after: done=%b timeout=%b expected 1 0", done, timeout);
        end
    endtask

    task automatic test_btn_stagger();
        do_reset();
        while (edge_no < 27) step();
        btn = 1'b1;
        repeat (3) begin
            step();
            n_tests++;
            if (obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL btn_press edge %0d: got %h expected %h", edge_no, obs, exp_vec());
            end
        end
        n_tests++;
        if (rst_out !== 2'b11) begin
            n_fail++;
            $display("FAIL btn_reassert: rst_out=%b expected 11", rst_out);
        end
        btn = 1'b0;
        while (edge_no < 75) begin
            step();
            n_tests++;
            if (obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL btn_restart edge %0d: got %h expected %h", edge_no, obs, exp_vec());
            end
            if (edge_no == 56 || edge_no == 57) begin
                n_tests++;
                if (rst_out !== ((edge_no == 56) ? 2'b11 : 2'b10)) begin
                    n_fail++;
                    $display("FAIL btn_release edge %0d: rst_out=%b", edge_no, rst_out);
                end
            end
        end
    endtask

    task automatic test_rst_mid_run();
        logic [N_DOM-1:0] er;
        do_reset();
        while (edge_no < 50) step();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (obs !== RST_VEC) begin
            n_fail++;
            $display("FAIL async_reset: got %h expected %h", obs, RST_VEC);
        end
        rst_n = 1'b1;
        model_reset();
        for (int e = 1; e <= 40; e++) begin
            step();
            n_tests++;
            if (obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL replay edge %0d: got %h expected %h", edge_no, obs, exp_vec());
            end
            if (edge_no == 24 || edge_no == 25 || edge_no == 29) begin
                er = (edge_no == 24) ? 2'b11 : (edge_no == 25) ? 2'b10 : 2'b00;
                n_tests++;
                if (rst_out !== er || running !== 1'b0) begin
                    n_fail++;
                    $display("FAIL replay_rst edge %0d: got %b expected %b", edge_no, rst_out, er);
                end
            end
            if (edge_no == 33) begin
                n_tests++;
                if (running !== 1'b1) begin
                    n_fail++;
                    $display("FAIL replay_running edge 33: got %b", running);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            do_reset();
            for (int i = 0; i < 300; i++) begin
                if (btn) btn = ($urandom_range(0, 3) != 0);
                else     btn = ($urandom_range(0, 149) == 0);
                halt = ($urandom_range(0, 89) == 0);
                step();
                n_tests++;
                if (obs !== exp_vec() || (done && timeout)) begin
                    n_fail++;
                    $display("FAIL random round %0d edge %0d: got %h expected %h", r, edge_no, obs, exp_vec());
                end
            end
        end
        btn  = 1'b0;
        halt = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        model_reset();
        test_reset();
        test_power_on();
        test_watchdog();
        test_halt();
        test_tie();
        test_btn_stagger();
        test_rst_mid_run();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
